// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        IWAIT = 2'd2
    } state_t;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam int          PEN_W    = 4;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flush penalty,
// instruction-memory wait states, plus stall/flush performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int BRANCH_PENALTY = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             imem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [PEN_W-1:0] PEN_INIT = PEN_W'(BRANCH_PENALTY - 1);

    state_t           state_reg, state_next;
    logic [PEN_W-1:0] pen_reg, pen_next;
    logic             load_use;
    logic             stall_en, flush_en;

    assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= RUN;
            pen_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pen_reg   <= pen_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pen_next   = pen_reg;
        case (state_reg)
            RUN: begin
                if (branch_taken) begin
                    // A redirect that misses imem waits it out; no penalty is owed afterwards.
                    if (!imem_ready) begin
                        state_next = IWAIT;
                    end else if (BRANCH_PENALTY > 1) begin
                        state_next = FLUSH;
                        pen_next   = PEN_INIT;
                    end
                end else if (!imem_ready) begin
                    state_next = IWAIT;
                end
            end
            FLUSH: begin
                if (imem_ready) begin
                    pen_next = pen_reg - PEN_W'(1);
                    if (pen_reg == PEN_W'(1)) begin
                        state_next = RUN;
                    end
                end
            end
            IWAIT: begin
                if (imem_ready) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
                pen_next   = '0;
            end
        endcase
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (!rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            case (state_reg)
                RUN: begin
                    if (branch_taken) begin
                        ifid_flush = 1'b1;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (!imem_ready) begin
                        pc_write   = 1'b0;
                        ifid_flush = 1'b1;
                    end
                end
                FLUSH: begin
                    pc_write   = imem_ready;
                    ifid_flush = 1'b1;
                end
                IWAIT: begin
                    if (!imem_ready) begin
                        pc_write   = 1'b0;
                        ifid_flush = 1'b1;
                    end
                end
                default: begin
                    pc_write = 1'b1;
                end
            endcase
        end
    end

    assign stall_en = rst && !pc_write;
    assign flush_en = rst && ifid_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_en),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (flush_en),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a BRANCH_PENALTY=3 instance plus a
// BRANCH_PENALTY=1 / CNT_W=4 instance sharing the same stimulus.
module tb_hazard_ctrl;

    localparam logic [3:0] DEF       = 4'b1100; // {pc_write, ifid_write, ifid_flush, idex_bubble}
    localparam logic [3:0] STALL     = 4'b0001;
    localparam logic [3:0] FLSH_RUN  = 4'b1110;
    localparam logic [3:0] IMEM_WAIT = 4'b0110;
    localparam logic [3:0] FORCED    = 4'b0011;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_mem_read, branch_taken, imem_ready;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble;
    logic        pc_write2, ifid_write2, ifid_flush2, idex_bubble2;
    logic [15:0] stall_cnt, flush_cnt;
    logic [3:0]  stall_cnt2, flush_cnt2;
    logic [3:0]  ctl, ctl2, exp_ctl;
    int          checks = 0;
    int          errors = 0;

    assign ctl  = {pc_write, ifid_write, ifid_flush, idex_bubble};
    assign ctl2 = {pc_write2, ifid_write2, ifid_flush2, idex_bubble2};

    always #5 clk = ~clk;

    hazard_ctrl #(.BRANCH_PENALTY(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.BRANCH_PENALTY(1), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .pc_write(pc_write2), .ifid_write(ifid_write2),
        .ifid_flush(ifid_flush2), .idex_bubble(idex_bubble2),
        .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        ex_rt = 5'd0; branch_taken = 1'b0; imem_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk); idle(); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk); idle(); rst = 1'b0;
        #1;
        checks++; if (ctl !== FORCED) begin errors++; $display("FAIL reset_forced ctl=%b exp=%b", ctl, FORCED); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
        checks++; if (flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_flush_cnt got=%0d exp=0", flush_cnt); end
        @(negedge clk); rst = 1'b1;
        #1;
        checks++; if (ctl !== DEF) begin errors++; $display("FAIL reset_release ctl=%b exp=%b", ctl, DEF); end
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk); ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        #1;
        checks++; if (ctl !== STALL) begin errors++; $display("FAIL lu_stall ctl=%b exp=%b", ctl, STALL); end
        @(negedge clk); idle();
        #1;
        checks++; if (ctl !== DEF) begin errors++; $display("FAIL lu_release ctl=%b exp=%b", ctl, DEF); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
        @(negedge clk); ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        checks++; if (ctl !== DEF) begin errors++; $display("FAIL lu_r0 ctl=%b exp=%b", ctl, DEF); end
        @(negedge clk); ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
        #1;
        checks++; if (ctl !== DEF) begin errors++; $display("FAIL lu_rt_unused ctl=%b exp=%b", ctl, DEF); end
        @(negedge clk); id_uses_rt = 1'b1;
        #1;
        checks++; if (ctl !== STALL) begin errors++; $display("FAIL lu_rt_used ctl=%b exp=%b", ctl, STALL); end
        @(negedge clk); idle();
        #1;
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL lu_stall_cnt2 got=%0d exp=2", stall_cnt); end
        checks++; if (flush_cnt !== 16'd0) begin errors++; $display("FAIL lu_flush_cnt got=%0d exp=0", flush_cnt); end
        $display("test_load_use done");
    endtask

    task automatic test_branch();
        do_reset();
        @(negedge clk); branch_taken = 1'b1;
        #1;
        checks++; if (ctl !== FLSH_RUN) begin errors++; $display("FAIL br_c1 ctl=%b exp=%b", ctl, FLSH_RUN); end
        checks++; if (ctl2 !== FLSH_RUN) begin errors++; $display("FAIL br_bp1_c1 ctl=%b exp=%b", ctl2, FLSH_RUN); end
        @(negedge clk); branch_taken = 1'b0; ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        #1;
        checks++; if (ctl !== FLSH_RUN) begin errors++; $display("FAIL br_c2 ctl=%b exp=%b", ctl, FLSH_RUN); end
        checks++; if (ctl2 !== STALL) begin errors++; $display("FAIL br_bp1_c2 ctl=%b exp=%b", ctl2, STALL); end
        @(negedge clk); idle(); branch_taken = 1'b1;
        #1;
        checks++; if (ctl !== FLSH_RUN) begin errors++; $display("FAIL br_c3 ctl=%b exp=%b", ctl, FLSH_RUN); end
        @(negedge clk); idle();
        #1;
        checks++; if (ctl !== DEF) begin errors++; $display("FAIL br_c4 ctl=%b exp=%b", ctl, DEF); end
        checks++; if (flush_cnt !== 16'd3) begin errors++; $display("FAIL br_flush_cnt got=%0d exp=3", flush_cnt); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL br_stall_cnt got=%0d exp=0", stall_cnt); end
        $display("test_branch done");
    endtask

    // mode 0: plain wait, 1: branch in first cycle, 2: load-use in first cycle
    task automatic test_imem_wait();
        for (int m = 0; m < 3; m++) begin
            do_reset();
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk); idle(); imem_ready = 1'b0;
                exp_ctl = IMEM_WAIT;
                if (c == 1 && m == 1) begin
                    branch_taken = 1'b1; exp_ctl = FLSH_RUN;
                end
                if (c == 1 && m == 2) begin
                    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; exp_ctl = STALL;
                end
                #1;
                checks++; if (ctl !== exp_ctl) begin errors++; $display("FAIL iw_m%0d_c%0d ctl=%b exp=%b", m, c, ctl, exp_ctl); end
            end
            @(negedge clk); idle();
            #1;
            checks++; if (ctl !== DEF) begin errors++; $display("FAIL iw_m%0d_ready ctl=%b exp=%b", m, ctl, DEF); end
            checks++; if (stall_cnt !== ((m == 1) ? 16'd3 : 16'd4)) begin errors++; $display("FAIL iw_m%0d_stall_cnt got=%0d", m, stall_cnt); end
            checks++; if (flush_cnt !== ((m == 2) ? 16'd3 : 16'd4)) begin errors++; $display("FAIL iw_m%0d_flush_cnt got=%0d", m, flush_cnt); end
            @(negedge clk); branch_taken = 1'b1;
            #1;
            checks++; if (ctl !== FLSH_RUN) begin errors++; $display("FAIL iw_m%0d_run ctl=%b exp=%b", m, ctl, FLSH_RUN); end
            $display("test_imem_wait mode %0d done", m);
        end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        @(negedge clk); branch_taken = 1'b1;
        @(negedge clk); idle();
        #1;
        checks++; if (ctl !== FLSH_RUN) begin errors++; $display("FAIL rmf_in_flush ctl=%b exp=%b", ctl, FLSH_RUN); end
        #1 rst = 1'b0;
        #1;
        checks++; if (ctl !== FORCED) begin errors++; $display("FAIL rmf_forced ctl=%b exp=%b", ctl, FORCED); end
        checks++; if (flush_cnt !== 16'd0) begin errors++; $display("FAIL rmf_flush_cnt got=%0d exp=0", flush_cnt); end
        @(negedge clk); rst = 1'b1;
        #1;
        checks++; if (ctl !== DEF) begin errors++; $display("FAIL rmf_release ctl=%b exp=%b", ctl, DEF); end
        @(negedge clk);
        #1;
        checks++; if (ctl !== DEF) begin errors++; $display("FAIL rmf_after ctl=%b exp=%b", ctl, DEF); end
        checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL rmf_cnts stall=%0d flush=%0d exp=0/0", stall_cnt, flush_cnt); end
        $display("test_reset_mid_flush done");
    endtask

    task automatic test_saturation();
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk); idle(); imem_ready = 1'b0;
            #1;
            checks++; if (stall_cnt2 !== 4'((c > 15) ? 15 : c)) begin errors++; $display("FAIL sat_c%0d got=%0d exp=%0d", c, stall_cnt2, (c > 15) ? 15 : c); end
        end
        checks++; if (stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_wide got=%0d exp=20", stall_cnt); end
        @(negedge clk); idle();
        $display("test_saturation done");
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_branch();
        test_imem_wait();
        test_reset_mid_flush();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Drives the PC write enable, IF/ID write enable, IF/ID flush and ID/EX bubble.
- Handles three conditions: load-use hazards, taken branches/jumps with a configurable penalty, and multi-cycle instruction-memory waits.
- Keeps saturating stall and flush counters for performance analysis.

Parameters:
- BRANCH_PENALTY, 1, number of consecutive cycles IF/ID is flushed per taken branch/jump (legal 1..15).
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous, active-low reset.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- id_uses_rt  input  1  ID instruction reads rt as a source.
- ex_mem_read  input  1  instruction in EX is a load.
- ex_rt  input  5  destination register of the load in EX.
- branch_taken  input  1  branch/jump resolved taken in ID this cycle.
- imem_ready  input  1  instruction memory returns valid data this cycle.
- pc_write  output  1  PC register update enable.
- ifid_write  output  1  IF/ID register load enable.
- ifid_flush  output  1  IF/ID loads a 32'b0 NOP instead of the fetched word.
- idex_bubble  output  1  ID/EX control fields are zeroed (bubble).
- stall_cnt  output  CNT_W  cycles with pc_write=0.
- flush_cnt  output  CNT_W  cycles with ifid_flush=1.

Behaviour:
- State register encodes RUN, FLUSH and IWAIT. A penalty counter pen (4 bits) is held alongside it.
- All control outputs are Mealy: they decode from the registered state and the current inputs.
- Reset (rst=0):
  - Asynchronous: state=RUN, pen=0, stall_cnt=0, flush_cnt=0.
  - While rst=0 the outputs are forced: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1.
- load_use = ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- Default outputs: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- RUN, rules in priority order:
  1. branch_taken=1:
     - Outputs: pc_write=1 (redirect always accepted), ifid_flush=1, idex_bubble=0.
     - Next state: if imem_ready=0, IWAIT. Else if BRANCH_PENALTY>1, FLUSH with pen=BRANCH_PENALTY-1. Else RUN.
     - load_use is ignored in this cycle.
  2. load_use=1:
     - Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
     - Next state: RUN. This is a single-cycle stall, because the load has advanced to MEM.
     - If imem_ready=0 in the same cycle, the outputs are unchanged and next state is IWAIT.
  3. imem_ready=0:
     - Outputs: pc_write=0, ifid_flush=1.
     - Next state: IWAIT.
- IWAIT:
  - While imem_ready=0: pc_write=0, ifid_flush=1, idex_bubble=0. branch_taken and load_use are ignored, since ID holds a NOP.
  - When imem_ready=1: outputs take their defaults (the fetched word is captured) and next state is RUN.
- FLUSH:
  - Outputs: ifid_flush=1, pc_write=imem_ready. branch_taken and load_use are ignored.
  - pen decrements only when imem_ready=1.
  - On pen==1 with imem_ready=1, next state is RUN.
- When ifid_flush=1, ifid_write is don't-care; drive it 1.
- Counters:
  - Each increments in a cycle where rst=1 and its condition holds.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset mid-FLUSH or mid-IWAIT abandons the sequence immediately; there is no pending-redirect memory.

Decomposition:
- Shared package hazard_pkg:
  - state typedef (RUN/FLUSH/IWAIT) and the NOP constant 32'h0.
  - Register-index constant REG_ZERO=5'd0.
- One natural sub-module: sat_counter (parameterised width, enable, async active-low reset), instantiated twice for the two performance counters.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 → exactly one cycle of pc_write=0, ifid_write=0, idex_bubble=1; the next cycle returns to defaults. Repeating with ex_rt=0 produces no stall.
- id_uses_rt=0, ex_rt=id_rt=9, id_rs=3, ex_mem_read=1 → no stall. Setting id_uses_rt=1 produces a one-cycle stall.
- BRANCH_PENALTY=3, branch_taken pulse, imem_ready=1 → ifid_flush=1 for 3 consecutive cycles with pc_write=1 throughout; flush_cnt increases by 3; a branch_taken in cycles 2-3 is ignored.
- imem_ready low for 4 cycles from RUN → pc_write=0 and ifid_flush=1 for 4 cycles, stall_cnt+4, RUN on the 5th cycle. Repeat with branch_taken and load_use in the first cycle: the branch cycle has pc_write=1, ifid_flush=1 then 3 cycles of pc_write=0; in the load_use case stall_cnt increments 4 times.
- rst asserted mid-FLUSH (pen=2) → outputs forced immediately; after release, state=RUN, counters 0, default outputs.
- CNT_W=4, hold imem_ready=0 for 20 cycles → stall_cnt saturates at 15 and never wraps.
